// File: rtl/arb4x1_8bits.sv
// rtl/arb4x1_8bits.sv - four-lane to one round-robin FIFO drain arbiter (option: ARB_STRICT_PRIO_EN)
module arb4x1_8bits #(
    parameter int         DATA_WIDTH = 8,
    parameter logic [1:0] PTR_RST    = 2'd0
) (
    input  logic                  clk_f,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic [3:0]            lane_en,
    input  logic [DATA_WIDTH-1:0] data_0,
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic [DATA_WIDTH-1:0] data_2,
    input  logic [DATA_WIDTH-1:0] data_3,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  empty_2,
    input  logic                  empty_3,
    input  logic                  almost_full_out,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic                  pop_2,
    output logic                  pop_3,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            grant,
    output logic                  idle,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_INIT   = 2'b01,
        ST_IDLE   = 2'b10,
        ST_ACTIVE = 2'b11
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [3:0]            lane_mask;
    logic [3:0]            req;
    logic [1:0]            scan_base;
    logic [2:0]            pick;
    logic                  do_pop;
    logic [1:0]            sel_idx;
    logic [3:0]            pop_vec;
    logic [DATA_WIDTH-1:0] lane_data [4];

    // Returns {found, lane}: first requesting lane scanning base, base+1, ... modulo 4.
    function automatic logic [2:0] pick_lane(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign lane_data[0] = data_0;
    assign lane_data[1] = data_1;
    assign lane_data[2] = data_2;
    assign lane_data[3] = data_3;

    assign req     = ~{empty_3, empty_2, empty_1, empty_0} & lane_mask;
    assign pick    = pick_lane(req, scan_base);
    assign sel_idx = pick[1:0];

    // A pop needs an active scheduler, no pending re-init, downstream room and a requester.
    assign do_pop  = (state_q == ST_ACTIVE) && !init && !almost_full_out && pick[2];
    assign pop_vec = do_pop ? (4'b0001 << sel_idx) : 4'b0000;
    assign {pop_3, pop_2, pop_1, pop_0} = pop_vec;
    assign state   = state_q;

`ifdef ARB_STRICT_PRIO_EN
    // Fixed priority: always start the scan at lane 0.
    assign scan_base = 2'd0;
`else
    logic [1:0] ptr;
    assign scan_base = ptr;

    // Round-robin pointer moves just past the lane that was served.
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            ptr <= PTR_RST;
        end else if (do_pop) begin
            ptr <= sel_idx + 2'd1;
        end
    end
`endif

    // Next-state logic; init from IDLE/ACTIVE always wins over traffic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init)          state_d = ST_INIT;
                else if (|req)     state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)          state_d = ST_INIT;
                else if (!(|req))  state_d = ST_IDLE;
            end
            default:   state_d = ST_RESET;
        endcase
    end

    // State register and registered idle flag tracking the IDLE state.
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
            idle    <= 1'b0;
        end else begin
            state_q <= state_d;
            idle    <= (state_d == ST_IDLE);
        end
    end

    // Lane mask is captured only while sitting in INIT with init held high.
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            lane_mask <= 4'b1111;
        end else if (state_q == ST_INIT && init) begin
            lane_mask <= lane_en;
        end
    end

    // Output word register: popped word appears one cycle after its pop.
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            grant     <= 2'd0;
        end else if (do_pop) begin
            data_out  <= lane_data[sel_idx];
            valid_out <= 1'b1;
            grant     <= sel_idx;
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule
